// File: rtl/watchdog_pkg.sv
// Shared types and defaults for the watchdog calculation path.
// Holds the arbiter FSM encoding and the default timeout limits.
package watchdog_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_BUSY,
      S_RUN,
      S_DONE
   } arb_state_t;

   localparam int CALC_START_TO = 16;
   localparam int CALC_RUN_TO   = 1024;
   localparam int CALC_TW       = 11;

   function automatic logic [1:0] port_onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: prefers the port that was not served last.
// Purely combinational; the last pointer lives in the caller.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       idx,
   output logic       valid
);

   always_comb begin
      valid = |req;
      idx   = 1'b0;
      if (req[~last]) begin
         idx = ~last;
      end else if (req[last]) begin
         idx = last;
      end
   end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one calculation core between two requesters, round-robin,
// with start and run watchdogs around each job.
module calc_arbiter
   import watchdog_pkg::*;
#(
   parameter int START_TO = CALC_START_TO,
   parameter int RUN_TO   = CALC_RUN_TO,
   parameter int TW       = CALC_TW
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [31:0] a0_p0,
   input  logic [31:0] a1_p0,
   input  logic [31:0] a0_p1,
   input  logic [31:0] a1_p1,
   output logic [1:0]  gnt,
   output logic [1:0]  done,
   output logic [31:0] result,
   output logic        err,
   output logic [31:0] core_a0,
   output logic [31:0] core_a1,
   output logic        start_calc,
   input  logic        core_busy,
   input  logic [31:0] core_result
);

   arb_state_t         state, state_nxt;
   logic [TW-1:0]      timer, timer_nxt;
   logic               owner, owner_nxt;
   logic               last, last_nxt;
   logic [1:0]         gnt_nxt, done_nxt;
   logic               start_nxt, err_nxt;
   logic signed [31:0] result_nxt, a0_nxt, a1_nxt;
   logic               pick_idx, pick_vld;

   rr_arb2 u_pick (
      .req   (req),
      .last  (last),
      .idx   (pick_idx),
      .valid (pick_vld)
   );

   // every output is a register; this process only computes next values
   always_comb begin
      state_nxt  = state;
      timer_nxt  = timer;
      owner_nxt  = owner;
      last_nxt   = last;
      gnt_nxt    = 2'b00;
      done_nxt   = 2'b00;
      start_nxt  = 1'b0;
      err_nxt    = err;
      result_nxt = result;
      a0_nxt     = core_a0;
      a1_nxt     = core_a1;
      case (state)
         S_IDLE: begin
            if (pick_vld) begin
               gnt_nxt   = port_onehot(pick_idx);
               owner_nxt = pick_idx;
               a0_nxt    = pick_idx ? a0_p1 : a0_p0;
               a1_nxt    = pick_idx ? a1_p1 : a1_p0;
               state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            start_nxt = 1'b1;
            timer_nxt = '0;
            state_nxt = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (core_busy) begin
               timer_nxt = '0;
               state_nxt = S_RUN;
            end else if (timer == TW'(START_TO - 1)) begin
               err_nxt    = 1'b1;
               result_nxt = '0;
               state_nxt  = S_DONE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_RUN: begin
            if (!core_busy) begin
               result_nxt = core_result;
               err_nxt    = 1'b0;
               state_nxt  = S_DONE;
            end else if (timer == TW'(RUN_TO - 1)) begin
               err_nxt    = 1'b1;
               result_nxt = '0;
               state_nxt  = S_DONE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         S_DONE: begin
            done_nxt  = port_onehot(owner);
            last_nxt  = owner;
            state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // last resets to port 1 so that port 0 wins the first contention
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         timer      <= '0;
         owner      <= 1'b0;
         last       <= 1'b1;
         gnt        <= 2'b00;
         done       <= 2'b00;
         start_calc <= 1'b0;
         err        <= 1'b0;
         result     <= '0;
         core_a0    <= '0;
         core_a1    <= '0;
      end else begin
         state      <= state_nxt;
         timer      <= timer_nxt;
         owner      <= owner_nxt;
         last       <= last_nxt;
         gnt        <= gnt_nxt;
         done       <= done_nxt;
         start_calc <= start_nxt;
         err        <= err_nxt;
         result     <= result_nxt;
         core_a0    <= a0_nxt;
         core_a1    <= a1_nxt;
      end
   end

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a small behavioural core model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_calc_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req;
   logic [31:0] a0_p0, a1_p0, a0_p1, a1_p1;
   logic [1:0]  gnt, done;
   logic [31:0] result;
   logic        err;
   logic [31:0] core_a0, core_a1;
   logic        start_calc;
   logic        core_busy = 1'b0;
   logic [31:0] core_result = '0;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   calc_arbiter #(
      .START_TO (16),
      .RUN_TO   (32),
      .TW       (11)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .a0_p0       (a0_p0),
      .a1_p0       (a1_p0),
      .a0_p1       (a0_p1),
      .a1_p1       (a1_p1),
      .gnt         (gnt),
      .done        (done),
      .result      (result),
      .err         (err),
      .core_a0     (core_a0),
      .core_a1     (core_a1),
      .start_calc  (start_calc),
      .core_busy   (core_busy),
      .core_result (core_result)
   );

   // core model: busy for cm_len cycles starting cm_delay cycles after start
   int          cm_delay = 2;
   int          cm_len   = 4;
   bit          cm_never = 1'b0;
   bit          cm_stuck = 1'b0;
   logic [31:0] cm_res   = '0;
   int          cm_cyc   = -1;

   always @(negedge clk) begin
      if (start_calc) cm_cyc = 0;
      else if (cm_cyc >= 0) cm_cyc = cm_cyc + 1;
      core_result = cm_res;
      if (cm_stuck) core_busy = 1'b1;
      else if (cm_never || cm_cyc < 0) core_busy = 1'b0;
      else core_busy = (cm_cyc >= cm_delay) && (cm_cyc < cm_delay + cm_len);
   end

   int bad = 0;
   int n_start = 0;
   int n_gnt = 0;
   int n_done = 0;

   always @(negedge clk) begin
      if (gnt != 2'b00 && done != 2'b00) bad++;
      if ($countones(gnt) > 1 || $countones(done) > 1) bad++;
      if (start_calc) n_start++;
      if (gnt != 2'b00) n_gnt++;
      if (done != 2'b00) n_done++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag,
                  $signed(got), got, $signed(exp), exp);
      end
   endtask

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic wait_gnt(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (gnt != 2'b00) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic wait_done(input int limit, output int n);
      n = -1;
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (done != 2'b00) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic check_reset(input string p);
      chk({p, "_gnt"}, 32'(gnt), 32'd0);
      chk({p, "_done"}, 32'(done), 32'd0);
      chk({p, "_start"}, 32'(start_calc), 32'd0);
      chk({p, "_err"}, 32'(err), 32'd0);
      chk({p, "_result"}, result, 32'd0);
      chk({p, "_a0"}, core_a0, 32'd0);
      chk({p, "_a1"}, core_a1, 32'd0);
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = 2'b00;
      tick;
      tick;
      rst = 1'b0;
   endtask

   int          n;
   int          s;
   logic [1:0]  g;
   logic [1:0]  exp_g [3];

   initial begin
      rst   = 1'b1;
      req   = 2'b00;
      a0_p0 = '0;
      a1_p0 = '0;
      a0_p1 = '0;
      a1_p1 = '0;
      tick;
      tick;
      check_reset("por");
      rst = 1'b0;

      // single request: gnt next cycle, start the cycle after, done 8 cycles after start
      a0_p0  = 32'd5;
      a1_p0  = -32'sd3;
      cm_res = 32'd42;
      req    = 2'b01;
      tick;
      chk("s_gnt", 32'(gnt), 32'd1);
      chk("s_start_early", 32'(start_calc), 32'd0);
      chk("s_a0", core_a0, 32'd5);
      chk("s_a1", core_a1, -32'sd3);
      req = 2'b00;
      tick;
      chk("s_start", 32'(start_calc), 32'd1);
      chk("s_gnt_pulse", 32'(gnt), 32'd0);
      wait_done(20, n);
      chk("s_done_lat", n, 32'd8);
      chk("s_done", 32'(done), 32'd1);
      chk("s_result", result, 32'd42);
      chk("s_err", 32'(err), 32'd0);

      // contention: both ports held, strict alternation starting at port 0
      do_reset;
      a0_p0 = 32'd7;
      a1_p0 = 32'd1;
      a0_p1 = -32'sd9;
      a1_p1 = 32'd2;
      exp_g[0] = 2'b01;
      exp_g[1] = 2'b10;
      exp_g[2] = 2'b01;
      s = n_start;
      req = 2'b11;
      for (int j = 0; j < 3; j++) begin
         cm_res = 32'(100 + j);
         wait_gnt(10, n);
         chk($sformatf("c_gnt%0d", j), 32'(gnt), 32'(exp_g[j]));
         chk($sformatf("c_a0_%0d", j), core_a0, (exp_g[j] == 2'b01) ? 32'd7 : -32'sd9);
         g = gnt;
         wait_done(20, n);
         if (j == 2) req = 2'b00;
         chk($sformatf("c_done%0d", j), 32'(done), 32'(g));
         chk($sformatf("c_result%0d", j), result, 32'(100 + j));
      end
      tick;
      chk("c_starts", n_start - s, 32'd3);

      // run timeout: busy stuck high; 32 run cycles then S_DONE then done
      cm_stuck = 1'b1;
      tick;
      req = 2'b10;
      wait_gnt(5, n);
      chk("r_gnt", 32'(gnt), 32'd2);
      req = 2'b00;
      tick;
      chk("r_start", 32'(start_calc), 32'd1);
      wait_done(60, n);
      chk("r_done_lat", n, 32'd34);
      chk("r_done", 32'(done), 32'd2);
      chk("r_err", 32'(err), 32'd1);
      chk("r_result", result, 32'd0);

      // recovery once busy drops
      cm_stuck = 1'b0;
      cm_res   = 32'd77;
      tick;
      tick;
      req = 2'b01;
      wait_gnt(5, n);
      chk("v_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      tick;
      chk("v_start", 32'(start_calc), 32'd1);
      wait_done(20, n);
      chk("v_done_lat", n, 32'd8);
      chk("v_err", 32'(err), 32'd0);
      chk("v_result", result, 32'd77);

      // start timeout: 16 wait cycles then S_DONE then done
      cm_never = 1'b1;
      req = 2'b01;
      wait_gnt(5, n);
      chk("t_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      tick;
      chk("t_start", 32'(start_calc), 32'd1);
      wait_done(40, n);
      chk("t_done_lat", n, 32'd17);
      chk("t_done", 32'(done), 32'd1);
      chk("t_err", 32'(err), 32'd1);
      chk("t_result", result, 32'd0);

      // mid-job reset during S_RUN
      cm_never = 1'b0;
      cm_len   = 20;
      cm_res   = 32'd55;
      a0_p0    = 32'd13;
      req = 2'b01;
      wait_gnt(5, n);
      chk("m_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      tick;
      tick;
      tick;
      tick;
      tick;
      rst = 1'b1;
      tick;
      check_reset("mid");
      rst = 1'b0;
      s = n_done;
      repeat (30) tick;
      chk("m_no_done", n_done - s, 32'd0);
      req = 2'b11;
      wait_gnt(5, n);
      chk("m_gnt_after", 32'(gnt), 32'd1);
      req = 2'b00;
      wait_done(40, n);
      chk("m_done", 32'(done), 32'd1);
      chk("m_result", result, 32'd55);

      // withdrawn request from port 1 during port 0's job
      cm_len = 6;
      req = 2'b01;
      wait_gnt(5, n);
      chk("w_gnt", 32'(gnt), 32'd1);
      req = 2'b00;
      tick;
      tick;
      req = 2'b10;
      tick;
      tick;
      tick;
      req = 2'b00;
      wait_done(30, n);
      chk("w_done", 32'(done), 32'd1);
      s = n_gnt;
      repeat (20) tick;
      chk("w_no_grant", n_gnt - s, 32'd0);

      chk("onehot_overlap", bad, 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
